// File: rtl/tlc_row_scheduler_if.sv
// Row-load handshake between the row scheduler (master) and the TLC5941 bit shifter (slave).
interface tlc_row_scheduler_if #(
    parameter int unsigned ROW_BITS = 3
);
    logic                shift_req;
    logic                shift_mode;
    logic [ROW_BITS-1:0] shift_row;
    logic                shift_ack;
    logic                shift_done;

    modport master (
        output shift_req,
        output shift_mode,
        output shift_row,
        input  shift_ack,
        input  shift_done
    );

    modport slave (
        input  shift_req,
        input  shift_mode,
        input  shift_row,
        output shift_ack,
        output shift_done
    );
endinterface

// File: rtl/tlc_row_scheduler.sv
// Sequences TLC5941 dot-correction boot and double-buffered grayscale row loads,
// swapping the displayed row on each grayscale-period wrap.
module tlc_row_scheduler #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned ROW_BITS = 3,
    parameter int unsigned UCNT_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       dc_reload,
    input  logic                       gs_wrap,
    tlc_row_scheduler_if.master        shift,
    output logic                       led_mode,
    output logic                       led_blank,
    output logic                       led_xlat,
    output logic [ROWS-1:0]            row_en,
    output logic                       frame_start,
    output logic [UCNT_W-1:0]          underrun_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DC_REQ,
        S_DC_WAIT,
        S_DC_LAT,
        S_GS_REQ,
        S_GS_WAIT,
        S_READY,
        S_SWAP1,
        S_SWAP2
    } state_t;

    state_t              state;
    logic                dc_pending;
    logic [ROW_BITS-1:0] disp_row;
    logic [ROW_BITS-1:0] row_next;
    logic [ROW_BITS-1:0] disp_next;
    logic                wrap_underrun;

    assign row_next  = (shift.shift_row == ROW_BITS'(ROWS - 1)) ? '0
                                                                 : shift.shift_row + ROW_BITS'(1);
    assign disp_next = (disp_row == ROW_BITS'(ROWS - 1)) ? '0 : disp_row + ROW_BITS'(1);

    // A wrap arriving before the next row is latched means the current row repeats.
    assign wrap_underrun = gs_wrap && (state inside {S_DC_REQ, S_DC_WAIT, S_DC_LAT,
                                                     S_GS_REQ, S_GS_WAIT});

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            shift.shift_req  <= 1'b0;
            shift.shift_mode <= 1'b1;
            shift.shift_row  <= '0;
            led_mode         <= 1'b1;
            led_blank        <= 1'b1;
            led_xlat         <= 1'b0;
            row_en           <= '0;
            frame_start      <= 1'b0;
            underrun_cnt     <= '0;
            dc_pending       <= 1'b1;
            disp_row         <= '0;
        end else if (!enable) begin
            state           <= S_IDLE;
            shift.shift_req <= 1'b0;
            shift.shift_row <= '0;
            led_mode        <= shift.shift_mode;
            led_blank       <= 1'b1;
            led_xlat        <= 1'b0;
            row_en          <= '0;
            frame_start     <= 1'b0;
            dc_pending      <= 1'b1;
            disp_row        <= '0;
        end else begin
            led_xlat    <= 1'b0;
            frame_start <= 1'b0;
            led_mode    <= shift.shift_mode;

            if (dc_reload) begin
                dc_pending <= 1'b1;
            end
            if (wrap_underrun && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + UCNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    led_blank        <= 1'b1;
                    row_en           <= '0;
                    shift.shift_req  <= 1'b1;
                    shift.shift_mode <= 1'b1;
                    state            <= S_DC_REQ;
                end
                S_DC_REQ: begin
                    if (shift.shift_ack) begin
                        shift.shift_req <= 1'b0;
                        state           <= S_DC_WAIT;
                    end
                end
                S_DC_WAIT: begin
                    if (shift.shift_done) begin
                        led_xlat <= 1'b1;
                        state    <= S_DC_LAT;
                    end
                end
                S_DC_LAT: begin
                    // A reload landing on the clear cycle must survive.
                    dc_pending       <= dc_reload;
                    shift.shift_req  <= 1'b1;
                    shift.shift_mode <= 1'b0;
                    shift.shift_row  <= disp_next;
                    state            <= S_GS_REQ;
                end
                S_GS_REQ: begin
                    if (shift.shift_ack) begin
                        shift.shift_req <= 1'b0;
                        state           <= S_GS_WAIT;
                    end
                end
                S_GS_WAIT: begin
                    if (shift.shift_done) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (gs_wrap) begin
                        led_blank <= 1'b1;
                        row_en    <= '0;
                        state     <= S_SWAP1;
                    end
                end
                S_SWAP1: begin
                    led_xlat <= 1'b1;
                    state    <= S_SWAP2;
                end
                S_SWAP2: begin
                    led_blank        <= 1'b0;
                    row_en           <= ROWS'(1) << shift.shift_row;
                    frame_start      <= (shift.shift_row == '0);
                    disp_row         <= shift.shift_row;
                    shift.shift_row  <= row_next;
                    shift.shift_req  <= 1'b1;
                    shift.shift_mode <= dc_pending;
                    state            <= dc_pending ? S_DC_REQ : S_GS_REQ;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
